// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer for the MEM stage of a pipelined core.
// Each load/store pending in the EX/MEM register becomes one memory transaction.
// The pipeline is stalled until the memory acknowledges or the wait times out.
// Misaligned accesses and timeouts raise a sticky error flag.
module mem_access_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             MEM_WRITE_M,
  input  logic             MEM_TO_REG_M,
  input  logic [WIDTH-1:0] ALU_OUT_M,
  input  logic [WIDTH-1:0] WRITE_DATA_M,
  output logic             MEM_REQ,
  output logic             MEM_WE,
  output logic [WIDTH-1:0] MEM_ADDR,
  output logic [WIDTH-1:0] MEM_WDATA,
  input  logic [WIDTH-1:0] MEM_RDATA,
  input  logic             MEM_ACK,
  output logic             STALL,
  output logic [WIDTH-1:0] READ_DATA_M,
  output logic             MEM_ERR
);

  // The wait counter only ever reaches TIMEOUT-1.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             req_q,   req_d;
  logic             we_q,    we_d;
  logic [WIDTH-1:0] addr_q,  addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q,   err_d;
  logic             stall_c;

  logic pending;
  logic aligned;

  assign pending = MEM_WRITE_M | MEM_TO_REG_M;
  assign aligned = (ALU_OUT_M[1:0] == 2'b00);

  // Next-state, next-register and combinational stall logic.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    stall_c = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pending) begin
          if (aligned) begin
            // Accept the access; a store wins when both flags are set.
            state_d = S_REQ;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = MEM_WRITE_M;
            addr_d  = ALU_OUT_M;
            wdata_d = WRITE_DATA_M;
            stall_c = 1'b1;
          end else begin
            // Misaligned: flag it and let the instruction pass without a request.
            err_d = 1'b1;
          end
        end
      end

      S_REQ: begin
        stall_c = 1'b1;
        if (MEM_ACK) begin
          // Acknowledge takes priority over a coincident timeout.
          state_d = S_DONE;
          cnt_d   = '0;
          req_d   = 1'b0;
          we_d    = 1'b0;
          if (!we_q) rdata_d = MEM_RDATA;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
          req_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          if (!we_q) rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DONE: begin
        // One unstalled cycle lets the pipeline advance past this instruction.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Reset must never hold the pipeline frozen.
    if (CLR) stall_c = 1'b0;
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (CLR) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign MEM_REQ     = req_q;
  assign MEM_WE      = we_q;
  assign MEM_ADDR    = addr_q;
  assign MEM_WDATA   = wdata_q;
  assign READ_DATA_M = rdata_q;
  assign MEM_ERR     = err_q;
  assign STALL       = stall_c;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl.
// The driver acts as the pipeline and keeps a transaction-level model.
// A responder plays the data memory, and a monitor scores each request phase.
module tb_mem_access_ctrl;

  localparam int W   = 32;
  localparam int TMO = 4;

  logic         CLK = 1'b0;
  logic         CLR;
  logic         MEM_WRITE_M, MEM_TO_REG_M;
  logic [W-1:0] ALU_OUT_M, WRITE_DATA_M;
  logic         MEM_REQ, MEM_WE;
  logic [W-1:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
  logic         MEM_ACK;
  logic         STALL;
  logic [W-1:0] READ_DATA_M;
  logic         MEM_ERR;

  mem_access_ctrl #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .CLK          (CLK),
    .CLR          (CLR),
    .MEM_WRITE_M  (MEM_WRITE_M),
    .MEM_TO_REG_M (MEM_TO_REG_M),
    .ALU_OUT_M    (ALU_OUT_M),
    .WRITE_DATA_M (WRITE_DATA_M),
    .MEM_REQ      (MEM_REQ),
    .MEM_WE       (MEM_WE),
    .MEM_ADDR     (MEM_ADDR),
    .MEM_WDATA    (MEM_WDATA),
    .MEM_RDATA    (MEM_RDATA),
    .MEM_ACK      (MEM_ACK),
    .STALL        (STALL),
    .READ_DATA_M  (READ_DATA_M),
    .MEM_ERR      (MEM_ERR)
  );

  always #5 CLK = ~CLK;

  // Expected outcome of one accepted memory access.
  typedef struct {
    logic         we;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic [W-1:0] rd;
    logic         err;
    int           reqc;
  } exp_t;

  exp_t         exp_q[$];
  int           ack_q[$];
  logic [W-1:0] rd_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  bit manual   = 1'b1;

  // Architectural model state.
  logic [W-1:0] m_rd  = '0;
  logic         m_err = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Present one instruction in MEM; returns at posedge+1 once the pipeline advanced.
  task automatic do_instr(input logic st, input logic ld, input logic [W-1:0] addr,
                          input logic [W-1:0] wd, input int dly, input logic [W-1:0] rd);
    int  stalls;
    int  exp_stall;
    bit  pend;
    bit  ok_align;
    bit  tmo;
    MEM_WRITE_M  = st;
    MEM_TO_REG_M = ld;
    ALU_OUT_M    = addr;
    WRITE_DATA_M = wd;
    pend      = st | ld;
    ok_align  = (addr % 4) == 0;
    exp_stall = 0;
    if (pend && ok_align) begin
      tmo = dly > TMO;
      if (!st) m_rd = tmo ? '0 : rd;
      if (tmo) m_err = 1'b1;
      exp_q.push_back('{we: st, addr: addr, wdata: wd, rd: m_rd, err: m_err,
                        reqc: (tmo ? TMO : dly)});
      ack_q.push_back(dly);
      rd_q.push_back(rd);
      exp_stall = tmo ? TMO + 1 : dly + 1;
    end else if (pend) begin
      m_err = 1'b1;
    end
    stalls = 0;
    @(negedge CLK);
    while (STALL === 1'b1 && stalls < 40) begin
      stalls++;
      @(negedge CLK);
    end
    check("stall_cycles", W'(stalls), W'(exp_stall));
    @(posedge CLK); #1;
    if (pend && !ok_align) begin
      check("misalign_err", W'(MEM_ERR), W'(1));
      check("misalign_noreq", W'(MEM_REQ), W'(0));
    end
  endtask

  // Memory responder: acknowledges the dly-th request cycle, plus stray ACKs when idle.
  initial begin
    int           cnt;
    int           d;
    logic [W-1:0] r;
    bit           in_req;
    in_req    = 1'b0;
    cnt       = 0;
    d         = 1000;
    r         = '0;
    MEM_ACK   = 1'b0;
    MEM_RDATA = '0;
    forever begin
      @(negedge CLK);
      if (manual) begin
        in_req = 1'b0;
        continue;
      end
      MEM_ACK   = 1'b0;
      MEM_RDATA = $urandom;
      if (MEM_REQ) begin
        if (!in_req) begin
          in_req = 1'b1;
          cnt    = 0;
          if (ack_q.size() > 0) begin
            d = ack_q.pop_front();
            r = rd_q.pop_front();
          end else begin
            d = 1000;
          end
        end
        cnt++;
        if (cnt == d) begin
          MEM_ACK   = 1'b1;
          MEM_RDATA = r;
        end
      end else begin
        in_req = 1'b0;
        if ($urandom_range(0, 3) == 0) MEM_ACK = 1'b1;
      end
    end
  end

  // Monitor: scores each request phase against the scoreboard.
  initial begin
    bit   prev;
    bit   changed;
    int   reqc;
    exp_t cur;
    prev    = 1'b0;
    changed = 1'b0;
    reqc    = 0;
    cur     = '{we: 1'b0, addr: '0, wdata: '0, rd: '0, err: 1'b0, reqc: 0};
    forever begin
      @(negedge CLK);
      if (manual) begin
        prev = 1'b0;
        continue;
      end
      if (MEM_REQ && !prev) begin
        check("exp_q_depth", W'(exp_q.size()), W'(1));
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        check("req_addr", MEM_ADDR, cur.addr);
        check("req_wdata", MEM_WDATA, cur.wdata);
        check("req_we", W'(MEM_WE), W'(cur.we));
        changed = 1'b0;
        reqc    = 1;
      end else if (MEM_REQ) begin
        reqc++;
        if (MEM_ADDR !== cur.addr || MEM_WDATA !== cur.wdata || MEM_WE !== cur.we) changed = 1'b1;
      end else if (prev) begin
        check("req_held", W'(changed), W'(0));
        check("req_cycles", W'(reqc), W'(cur.reqc));
        check("done_read_data", READ_DATA_M, cur.rd);
        check("done_err", W'(MEM_ERR), W'(cur.err));
        check("done_stall", W'(STALL), W'(0));
      end
      prev = MEM_REQ;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  // Main stimulus.
  initial begin
    logic [W-1:0] a;
    int           k;
    bit           st;
    bit           ld;

    CLR          = 1'b1;
    MEM_WRITE_M  = 1'b0;
    MEM_TO_REG_M = 1'b1;
    ALU_OUT_M    = 32'h100;
    WRITE_DATA_M = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_stall", W'(STALL), W'(0));
    check("rst_req", W'(MEM_REQ), W'(0));
    check("rst_we", W'(MEM_WE), W'(0));
    check("rst_addr", MEM_ADDR, W'(0));
    check("rst_wdata", MEM_WDATA, W'(0));
    check("rst_read_data", READ_DATA_M, W'(0));
    check("rst_err", W'(MEM_ERR), W'(0));
    @(posedge CLK); #1;
    CLR          = 1'b0;
    MEM_TO_REG_M = 1'b0;
    manual       = 1'b0;

    // Directed scenarios.
    do_instr(1'b0, 1'b1, 32'h100, 32'h0,        3, 32'hDEADBEEF);
    do_instr(1'b1, 1'b0, 32'h40,  32'h12345678, 1, 32'h0BADF00D);
    check("store_keeps_rd", READ_DATA_M, 32'hDEADBEEF);
    check("store_no_err", W'(MEM_ERR), W'(0));
    do_instr(1'b0, 1'b1, 32'h102, 32'h0,        1, 32'h0);
    do_instr(1'b0, 1'b1, 32'h80,  32'h0,        TMO + 1, 32'h55555555);
    do_instr(1'b0, 1'b1, 32'h84,  32'h0,        TMO, 32'hA5A5A5A5);
    do_instr(1'b0, 1'b1, 32'h10,  32'h0,        1, 32'h11111111);
    do_instr(1'b0, 1'b1, 32'h14,  32'h0,        1, 32'h22222222);
    do_instr(1'b1, 1'b1, 32'h20,  32'hCAFEF00D, 2, 32'h33333333);
    do_instr(1'b0, 1'b0, 32'h24,  32'h0,        1, 32'h0);

    // Randomised mix of loads, stores, bubbles, misaligned and timed-out accesses.
    for (int i = 0; i < 150; i++) begin
      k  = $urandom_range(0, 9);
      a  = $urandom;
      st = $urandom_range(0, 1) == 1;
      ld = !st || ($urandom_range(0, 3) == 0);
      if (k == 0) begin
        st = 1'b0;
        ld = 1'b0;
      end
      if (k == 1) a[1:0] = 2'($urandom_range(1, 3));
      else        a[1:0] = 2'b00;
      do_instr(st, ld, a, $urandom, $urandom_range(1, TMO + 2), $urandom);
    end

    // Clear in the middle of a request, with a late acknowledge.
    manual       = 1'b1;
    MEM_ACK      = 1'b0;
    MEM_WRITE_M  = 1'b0;
    MEM_TO_REG_M = 1'b1;
    ALU_OUT_M    = 32'h200;
    @(posedge CLK); #1;
    check("clr_req_up", W'(MEM_REQ), W'(1));
    @(posedge CLK); #1;
    CLR = 1'b1;
    @(negedge CLK);
    check("clr_stall", W'(STALL), W'(0));
    @(posedge CLK); #1;
    CLR          = 1'b0;
    MEM_TO_REG_M = 1'b0;
    MEM_ACK      = 1'b1;
    MEM_RDATA    = 32'hBAD0BAD0;
    @(negedge CLK);
    check("clr_req", W'(MEM_REQ), W'(0));
    check("clr_we", W'(MEM_WE), W'(0));
    check("clr_addr", MEM_ADDR, W'(0));
    check("clr_wdata", MEM_WDATA, W'(0));
    check("clr_read_data", READ_DATA_M, W'(0));
    check("clr_err", W'(MEM_ERR), W'(0));
    check("clr_idle_stall", W'(STALL), W'(0));
    @(posedge CLK); #1;
    MEM_ACK = 1'b0;
    @(negedge CLK);
    check("late_ack_read_data", READ_DATA_M, W'(0));
    check("late_ack_req", W'(MEM_REQ), W'(0));
    check("late_ack_err", W'(MEM_ERR), W'(0));

    check("exp_q_drained", W'(exp_q.size()), W'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, data and address width.
REQ-002 Parameter TIMEOUT, default 255, max cycles waiting for MEM_ACK before abort.
REQ-003 One clock, CLK; reset CLR is synchronous and active-high.
REQ-004 CLK  input  1  clock, all state updates on rising edge.
REQ-005 CLR  input  1  synchronous active-high reset.
REQ-006 MEM_WRITE_M  input  1  store pending in EX/MEM register.
REQ-007 MEM_TO_REG_M  input  1  load pending in EX/MEM register.
REQ-008 ALU_OUT_M  input  WIDTH  access byte address.
REQ-009 WRITE_DATA_M  input  WIDTH  store data.
REQ-010 MEM_REQ  output  1  request to data memory.
REQ-011 MEM_WE  output  1  write enable, valid while MEM_REQ=1.
REQ-012 MEM_ADDR  output  WIDTH  registered access address.
REQ-013 MEM_WDATA  output  WIDTH  registered store data.
REQ-014 MEM_RDATA  input  WIDTH  load data, valid with MEM_ACK.
REQ-015 MEM_ACK  input  1  memory completion, single-cycle pulse.
REQ-016 STALL  output  1  freezes F/D/E/M pipeline registers when 1.
REQ-017 READ_DATA_M  output  WIDTH  captured load data for writeback.
REQ-018 MEM_ERR  output  1  sticky error flag (timeout or misalignment).

Function
REQ-019 FSM states IDLE, REQ, DONE; block SHALL sequence one memory access per instruction in MEM stage.
REQ-020 Access pending = MEM_WRITE_M | MEM_TO_REG_M; both set SHALL be treated as store (MEM_WE=1, no capture).
REQ-021 IDLE, pending, ALU_OUT_M[1:0]==0: SHALL register ALU_OUT_M/WRITE_DATA_M/store-flag, go REQ, STALL=1 same cycle (combinational).
REQ-022 IDLE, pending, ALU_OUT_M[1:0]!=0: SHALL set MEM_ERR, issue no request, not stall, remain IDLE.
REQ-023 REQ: MEM_REQ=1, STALL=1, MEM_ADDR/MEM_WDATA/MEM_WE held constant; wait counter increments each cycle from 0.
REQ-024 REQ with MEM_ACK=1: SHALL go DONE; on load capture MEM_RDATA into READ_DATA_M at that edge.
REQ-025 REQ with counter==TIMEOUT-1 and MEM_ACK=0: SHALL go DONE, set MEM_ERR, load READ_DATA_M=0.
REQ-026 MEM_ACK and timeout in same cycle: ACK SHALL win, no error.
REQ-027 DONE: MEM_REQ=0, STALL=0 for exactly one cycle so pipeline advances; unconditional return to IDLE.
REQ-028 Store latency: pipeline stalled N+1 cycles for ACK received N cycles after entering REQ (N>=1 for first REQ cycle).
REQ-029 MEM_ACK in IDLE or DONE SHALL be ignored.
REQ-030 READ_DATA_M SHALL hold last captured value until next load completion; stores leave it unchanged.
REQ-031 MEM_ERR SHALL stay 1 until CLR; further accesses still serviced normally.
REQ-032 MEM_REQ, MEM_WE SHALL be registered outputs (glitch-free); STALL combinational from state and inputs.

Reset
REQ-033 CLR=1 at edge: state IDLE, counter 0, MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, READ_DATA_M=0, MEM_ERR=0.
REQ-034 CLR mid-access (REQ) SHALL abort immediately; MEM_REQ=0 next cycle; late MEM_ACK ignored.
REQ-035 While CLR=1, STALL SHALL be 0.

Verification
REQ-036 Load, ALU_OUT_M=0x100, ACK 3 cycles after MEM_REQ rises with MEM_RDATA=0xDEADBEEF -> READ_DATA_M=0xDEADBEEF, STALL high 4 cycles, then 1 DONE cycle with STALL=0.
REQ-037 Store, ALU_OUT_M=0x40, WRITE_DATA_M=0x12345678, ACK after 1 cycle -> MEM_WE=1, MEM_WDATA=0x12345678, READ_DATA_M unchanged, MEM_ERR=0.
REQ-038 Load, ALU_OUT_M=0x102 -> no MEM_REQ, STALL=0, MEM_ERR=1 next cycle.
REQ-039 TIMEOUT=4, load, no ACK -> MEM_REQ high 4 cycles, then DONE, MEM_ERR=1, READ_DATA_M=0; ACK on 4th cycle instead -> no error.
REQ-040 CLR asserted 2 cycles into REQ, ACK pulsed next cycle -> all outputs reset values, state IDLE, READ_DATA_M=0.
REQ-041 Back-to-back loads 0x10 then 0x14, each ACK after 1 cycle -> two distinct MEM_REQ phases separated by one DONE cycle, each address issued once.
